mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data_memory port (addr/writedata/re/we/size/readdata) between two requesters.
  - Port 0: processor load/store path.
  - Port 1: serial boot loader / DMA.
- Sits between the requesters and data_memory. Sequences each access through a fixed issue/wait/respond FSM and returns read data with a one-cycle ack to the winner.

Parameters:
- MEM_LAT, 1, cycles from mem_re/mem_we assertion to valid mem_rdata; legal range 1..15.
- FIXED_PRIO, 0, 0 = round-robin on ties; 1 = port 0 always wins ties.

Ports:
- clock  in  1  single clock; all state updates on posedge clock.
- reset  in  1  synchronous, active-low reset (reset==0 sampled at posedge clears state).
- req0  in  1  port 0 request; held until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  32  port 0 address.
- wdata0  in  32  port 0 write data.
- size0  in  2  port 0 access size; passed through to mem_size.
- ack0  out  1  one-cycle completion pulse to port 0.
- req1, we1, addr1, wdata1, size1, ack1: same meaning for port 1.
- rdata  out  32  last captured read data; valid in the ack cycle.
- mem_addr  out  32  to data_memory addr_in.
- mem_wdata  out  32  to data_memory writedata_in.
- mem_size  out  2  to data_memory size_in.
- mem_re  out  1  to data_memory re_in.
- mem_we  out  1  to data_memory we_in.
- mem_rdata  in  32  from data_memory readdata_out.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  id of the latched winner; valid when busy.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req0 or req1 is high, pick the winner.
  - Latch the winner's we/addr/wdata/size into internal registers; latch grant_id.
  - Next state ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive mem_addr/mem_wdata/mem_size from the latched registers.
  - mem_re = ~we_l, mem_we = we_l.
  - Load the countdown with MEM_LAT; next state WAIT.
- WAIT:
  - mem_re/mem_we low; mem_addr/mem_wdata/mem_size hold the latched values.
  - Countdown decrements each cycle.
  - In the cycle the count reaches 1: capture mem_rdata into rdata if read (writes leave rdata unchanged); next state RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (one cycle):
  - Pulse ack of grant_id.
  - Record last = grant_id; next state IDLE.
- Latency: request first sampled in IDLE at cycle t; ack high at cycle t+MEM_LAT+2. Max throughput is one access per MEM_LAT+3 cycles.
- Arbitration:
  - Single requester: it wins.
  - Both requesting, FIXED_PRIO=1: port 0 wins.
  - Both requesting, FIXED_PRIO=0: the port != last wins. last resets to 1, so port 0 wins the first tie.
  - A loser keeps req high and is granted at the next IDLE. Under round-robin there is no starvation: with both requesting continuously, grants alternate.
- Request fields are sampled only in IDLE. Changes to addr/we/wdata after grant have no effect on the current access.
- A requester dropping req after grant does not abort the access; ack still pulses.
- ack0 and ack1 are never high together. Neither is high outside RESP.
- Reset values: state IDLE, last=1, rdata=0, ack0=ack1=0, mem_re=mem_we=0, mem_addr=mem_wdata=0, mem_size=0, busy=0, grant_id=0.
- Reset mid-operation: state returns to IDLE next cycle and the in-flight access is dropped with no ack. If a write was already issued in ISSUE, it is not undone; requesters re-issue after reset.
- A request present while reset is low is ignored until reset is high.

Decomposition:
- Shared header (arb_defs):
  - State encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - Port ids (PORT_CPU=1'b0, PORT_LDR=1'b1).
  - Countdown width (4).
- One sub-module, arb_pick: combinational winner select from req0, req1, last, FIXED_PRIO → grant, valid.
- The FSM, latches and countdown stay in mem_port_arbiter.

Test Plan:
- MEM_LAT=1. Port 0 read addr 0x0000_0010 at cycle 0, memory returns 0xDEADBEEF → mem_re high only at cycle 1, ack0 at cycle 3, rdata=0xDEADBEEF, ack1 never high.
- MEM_LAT=3. Port 1 write addr 0x0000_0020 data 0x12345678 → mem_we high one cycle at cycle 1 with those values, ack1 at cycle 5, rdata unchanged.
- FIXED_PRIO=0. req0 and req1 held high continuously after reset → grant order 0,1,0,1; acks spaced MEM_LAT+3 cycles apart.
- FIXED_PRIO=1. Both held high for 3 transactions → three ack0 pulses, no ack1. Then drop req0 → ack1 follows.
- Port 0 read granted; reset driven low for 1 cycle during WAIT → no ack0, all outputs at reset values next cycle. Then req0 still high → fresh access, ack0 at MEM_LAT+2 after the first IDLE cycle.
- Port 0 changes addr0 from 0x10 to 0x40 in the ISSUE cycle → mem_addr stays 0x10 throughout the access.

Source files
------------

// File: rtl/arb_defs.sv
// Shared definitions for the data-memory port arbiter:
// FSM state encodings, requester ids and countdown width.
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the CPU and loader ports.
// Ties go to port 0 (fixed) or to the port that was not served last.
module arb_pick
    import arb_defs::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic grant_o,
    output logic valid_o
);

    // Pick a winner from the current requests and the last-served id.
    always_comb begin
        valid_o = req0_i | req1_i;
        grant_o = PORT_CPU;
        unique case (1'b1)
            (req0_i & req1_i): begin
                grant_o = (FIXED_PRIO != 0) ? PORT_CPU : ~last_i;
            end
            (~req0_i & req1_i): grant_o = PORT_LDR;
            default:            grant_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data_memory port between the CPU and the loader,
// sequencing each access through IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
    import arb_defs::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  size0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [CNT_W-1:0] LAT_CNT = MEM_LAT[CNT_W-1:0];

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;

    logic pick_grant;
    logic pick_valid;

    arb_pick #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_q),
        .grant_o(pick_grant),
        .valid_o(pick_valid)
    );

    // State, latched request and captured data registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_LDR;
            grant_q <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: latch the winner in IDLE, count down the memory latency.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    we_d    = pick_grant ? we1    : we0;
                    addr_d  = pick_grant ? addr1  : addr0;
                    wdata_d = pick_grant ? wdata1 : wdata0;
                    size_d  = pick_grant ? size1  : size0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_CNT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign mem_re    = (state_q == ST_ISSUE) & ~we_q;
    assign mem_we    = (state_q == ST_ISSUE) & we_q;
    assign ack0      = (state_q == ST_RESP) & (grant_q == PORT_CPU);
    assign ack1      = (state_q == ST_RESP) & (grant_q == PORT_LDR);
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with different latency
// and priority settings, each backed by a small latency-pipe memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn   [N];
    logic        req0   [N];
    logic        we0    [N];
    logic [31:0] addr0  [N];
    logic [31:0] wdata0 [N];
    logic [1:0]  size0  [N];
    logic        req1   [N];
    logic        we1    [N];
    logic [31:0] addr1  [N];
    logic [31:0] wdata1 [N];
    logic [1:0]  size1  [N];
    logic        ack0   [N];
    logic        ack1   [N];
    logic        busy   [N];
    logic        gid    [N];
    logic        mre    [N];
    logic        mwe    [N];
    logic [31:0] rdata  [N];
    logic [31:0] maddr  [N];
    logic [31:0] mwdata [N];
    logic [31:0] mrdata [N];
    logic [1:0]  msize  [N];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L  = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
        localparam int FP = (g == 2) ? 1 : 0;

        logic        pv [L];
        logic [31:0] pd [L];

        always @(posedge clk) begin
            pv[0] <= mre[g];
            pd[0] <= mem_fn(maddr[g]);
            for (int k = 1; k < L; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end

        assign mrdata[g] = (pv[L-1] === 1'b1) ? pd[L-1] : 32'hBAD0_BAD0;

        mem_port_arbiter #(
            .MEM_LAT   (L),
            .FIXED_PRIO(FP)
        ) u_dut (
            .clock    (clk),
            .reset    (rstn[g]),
            .req0     (req0[g]),
            .we0      (we0[g]),
            .addr0    (addr0[g]),
            .wdata0   (wdata0[g]),
            .size0    (size0[g]),
            .ack0     (ack0[g]),
            .req1     (req1[g]),
            .we1      (we1[g]),
            .addr1    (addr1[g]),
            .wdata1   (wdata1[g]),
            .size1    (size1[g]),
            .ack1     (ack1[g]),
            .rdata    (rdata[g]),
            .mem_addr (maddr[g]),
            .mem_wdata(mwdata[g]),
            .mem_size (msize[g]),
            .mem_re   (mre[g]),
            .mem_we   (mwe[g]),
            .mem_rdata(mrdata[g]),
            .busy     (busy[g]),
            .grant_id (gid[g])
        );
    end

    task automatic test_reset();
        for (int g = 0; g < N; g++) rstn[g] = 1'b0;
        req0[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                checks++;
                if ({busy[g], ack0[g], ack1[g], mre[g], mwe[g], gid[g]} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset_ctl inst=%0d busy/ack0/ack1/re/we/gid=%b%b%b%b%b%b expected 000000",
                             g, busy[g], ack0[g], ack1[g], mre[g], mwe[g], gid[g]);
                end
                checks++;
                if (maddr[g] !== 32'h0 || mwdata[g] !== 32'h0 || msize[g] !== 2'h0 || rdata[g] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data inst=%0d addr=%h wdata=%h size=%h rdata=%h expected all 0",
                             g, maddr[g], mwdata[g], msize[g], rdata[g]);
                end
            end
        end
        req0[0] = 1'b0;
        for (int g = 0; g < N; g++) rstn[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            checks++;
            if (busy[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle inst=%0d busy=%b expected 0", g, busy[g]);
            end
        end
    endtask

    task automatic test_read_lat1();
        exp_t e;
        bit   got;
        got = 1'b0;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h10; size0[0] = 2'd2;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (mre[0] !== (k == 1) || mwe[0] !== 1'b0) begin
                errors++;
                $display("FAIL rd1_re cyc=%0d re=%b we=%b expected re=%b we=0", k, mre[0], mwe[0], k == 1);
            end
            if (k == 1) begin
                checks++;
                if (maddr[0] !== 32'h10 || msize[0] !== 2'd2 || busy[0] !== 1'b1 || gid[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL rd1_issue addr=%h size=%h busy=%b gid=%b expected 10/2/1/0",
                             maddr[0], msize[0], busy[0], gid[0]);
                end
            end
            checks++;
            if (ack0[0] !== (k == 3) || ack1[0] !== 1'b0) begin
                errors++;
                $display("FAIL rd1_ack cyc=%0d ack0=%b ack1=%b expected ack0=%b ack1=0", k, ack0[0], ack1[0], k == 3);
            end
            if (ack0[0] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got = 1'b1;
                checks++;
                if (rdata[0] !== e.data) begin
                    errors++;
                    $display("FAIL rd1_data rdata=%h expected %h", rdata[0], e.data);
                end
                req0[0] = 1'b0;
            end
        end
        req0[0] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rd1_timeout no ack0 seen");
        end
        sb.delete();
    endtask

    task automatic test_write_lat3();
        exp_t e;
        bit   got;
        got = 1'b0;
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 32'h30; size0[1] = 2'd2;
        sb.push_back('{1'b0, mem_fn(32'h30)});
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            if (ack0[1] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got = 1'b1;
                checks++;
                if (rdata[1] !== e.data) begin
                    errors++;
                    $display("FAIL wr3_pre_read rdata=%h expected %h", rdata[1], e.data);
                end
                req0[1] = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr3_pre_timeout no ack0 seen");
        end
        req0[1] = 1'b0;
        sb.delete();
        @(negedge clk);
        got = 1'b0;
        req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 32'h20;
        wdata1[1] = 32'h1234_5678; size1[1] = 2'd2;
        sb.push_back('{1'b1, mem_fn(32'h30)});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (mwe[1] !== (k == 1) || mre[1] !== 1'b0) begin
                errors++;
                $display("FAIL wr3_we cyc=%0d we=%b re=%b expected we=%b re=0", k, mwe[1], mre[1], k == 1);
            end
            if (k == 1) begin
                checks++;
                if (maddr[1] !== 32'h20 || mwdata[1] !== 32'h1234_5678 || gid[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL wr3_issue addr=%h wdata=%h gid=%b expected 20/12345678/1",
                             maddr[1], mwdata[1], gid[1]);
                end
            end
            checks++;
            if (ack1[1] !== (k == 5) || ack0[1] !== 1'b0) begin
                errors++;
                $display("FAIL wr3_ack cyc=%0d ack1=%b ack0=%b expected ack1=%b ack0=0", k, ack1[1], ack0[1], k == 5);
            end
            if (ack1[1] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got = 1'b1;
                checks++;
                if (rdata[1] !== e.data) begin
                    errors++;
                    $display("FAIL wr3_rdata_kept rdata=%h expected %h", rdata[1], e.data);
                end
                req1[1] = 1'b0;
            end
        end
        req1[1] = 1'b0; we1[1] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr3_timeout no ack1 seen");
        end
        sb.delete();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n_ack;
        int   last_k;
        int   want_k;
        @(negedge clk);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h100; size0[0] = 2'd2;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h200; size1[0] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{bit'(i % 2), mem_fn((i % 2 == 1) ? 32'h200 : 32'h100)});
        end
        n_ack  = 0;
        last_k = 0;
        for (int k = 1; k <= 30 && n_ack < 4; k++) begin
            @(negedge clk);
            if (ack0[0] === 1'b1 || ack1[0] === 1'b1) begin
                checks++;
                if (ack0[0] === 1'b1 && ack1[0] === 1'b1) begin
                    errors++;
                    $display("FAIL rr_excl cyc=%0d ack0=1 ack1=1 expected one-hot", k);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra cyc=%0d ack with nothing expected", k);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (ack1[0] !== e.port || gid[0] !== e.port) begin
                        errors++;
                        $display("FAIL rr_order n=%0d ack1=%b gid=%b expected port %0d", n_ack, ack1[0], gid[0], e.port);
                    end
                    checks++;
                    if (rdata[0] !== e.data) begin
                        errors++;
                        $display("FAIL rr_data n=%0d rdata=%h expected %h", n_ack, rdata[0], e.data);
                    end
                end
                want_k = (n_ack == 0) ? 3 : last_k + 4;
                checks++;
                if (k != want_k) begin
                    errors++;
                    $display("FAIL rr_spacing n=%0d cyc=%0d expected cyc=%0d", n_ack, k, want_k);
                end
                last_k = k;
                n_ack++;
                if (n_ack == 4) begin
                    req0[0] = 1'b0;
                    req1[0] = 1'b0;
                end
            end
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL rr_timeout acks=%0d expected 4", n_ack);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        exp_t e;
        int   n_ack;
        req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 32'h300; size0[2] = 2'd2;
        req1[2] = 1'b1; we1[2] = 1'b0; addr1[2] = 32'h400; size1[2] = 2'd2;
        for (int i = 0; i < 3; i++) sb.push_back('{1'b0, mem_fn(32'h300)});
        sb.push_back('{1'b1, mem_fn(32'h400)});
        n_ack = 0;
        for (int k = 1; k <= 40 && n_ack < 4; k++) begin
            @(negedge clk);
            if (ack0[2] === 1'b1 || ack1[2] === 1'b1) begin
                checks++;
                if (ack0[2] === 1'b1 && ack1[2] === 1'b1) begin
                    errors++;
                    $display("FAIL fp_excl cyc=%0d ack0=1 ack1=1 expected one-hot", k);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL fp_extra cyc=%0d ack with nothing expected", k);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (ack1[2] !== e.port) begin
                        errors++;
                        $display("FAIL fp_order n=%0d ack1=%b expected port %0d", n_ack, ack1[2], e.port);
                    end
                    checks++;
                    if (rdata[2] !== e.data) begin
                        errors++;
                        $display("FAIL fp_data n=%0d rdata=%h expected %h", n_ack, rdata[2], e.data);
                    end
                end
                n_ack++;
                if (n_ack == 3) req0[2] = 1'b0;
                if (n_ack == 4) req1[2] = 1'b0;
            end
        end
        req0[2] = 1'b0;
        req1[2] = 1'b0;
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL fp_timeout acks=%0d expected 4", n_ack);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 32'h50; size0[1] = 2'd2;
        @(negedge clk);
        checks++;
        if (mre[1] !== 1'b1 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL rm_issue re=%b busy=%b expected 1/1", mre[1], busy[1]);
        end
        @(negedge clk);
        rstn[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy[1], ack0[1], ack1[1], mre[1], mwe[1], gid[1]} !== 6'b0 ||
            maddr[1] !== 32'h0 || mwdata[1] !== 32'h0 || msize[1] !== 2'h0 || rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL rm_cleared busy=%b ack0=%b re=%b addr=%h size=%h rdata=%h expected all 0",
                     busy[1], ack0[1], mre[1], maddr[1], msize[1], rdata[1]);
        end
        rstn[1] = 1'b1;
        sb.push_back('{1'b0, mem_fn(32'h50)});
        for (int k = 4; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (ack0[1] !== (k == 8)) begin
                errors++;
                $display("FAIL rm_ack cyc=%0d ack0=%b expected %b", k, ack0[1], k == 8);
            end
            if (ack0[1] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got = 1'b1;
                checks++;
                if (rdata[1] !== e.data) begin
                    errors++;
                    $display("FAIL rm_data rdata=%h expected %h", rdata[1], e.data);
                end
                req0[1] = 1'b0;
            end
        end
        req0[1] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rm_timeout no ack0 after reset");
        end
        sb.delete();
    endtask

    task automatic test_addr_change();
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h10; size0[0] = 2'd2;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                checks++;
                if (maddr[0] !== 32'h10) begin
                    errors++;
                    $display("FAIL ac_addr cyc=%0d mem_addr=%h expected 00000010", k, maddr[0]);
                end
            end
            if (k == 1) addr0[0] = 32'h40;
            if (ack0[0] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got = 1'b1;
                checks++;
                if (rdata[0] !== e.data || k != 3) begin
                    errors++;
                    $display("FAIL ac_data cyc=%0d rdata=%h expected %h at cyc 3", k, rdata[0], e.data);
                end
                req0[0] = 1'b0;
            end
        end
        req0[0] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ac_timeout no ack0 seen");
        end
        sb.delete();
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            rstn[g]   = 1'b0;
            req0[g]   = 1'b0; we0[g] = 1'b0; addr0[g] = '0; wdata0[g] = '0; size0[g] = '0;
            req1[g]   = 1'b0; we1[g] = 1'b0; addr1[g] = '0; wdata1[g] = '0; size1[g] = '0;
        end
        test_reset();
        test_read_lat1();
        @(negedge clk);
        test_write_lat3();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_addr_change();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
